reg_share_arbiter: RTL
======================

# reg_share_arbiter

Controller that shares one WIDTH-bit holding register (2:1 select mux feeding a D register) between two requesters. It arbitrates between the requests, drives the mux select, loads the winner's data into the register, acknowledges the winner, and holds the value for a programmable number of cycles so it stays visible on the board LEDs. It sits between the switch- or key-driven request sources and the LEDR display path of the DE1 lab designs.

## Interface
- WIDTH, 4: width of each data input and of the shared register.
- HOLD_CYCLES, 3: cycles the loaded value is held before a new grant is allowed; legal range 1 to 255.
- One clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  requests from requesters 0 and 1; level-sensitive.
- d0, d1  in  WIDTH  data from requesters 0 and 1.
- sel  out  1  mux select (0 = d0, 1 = d1); registered.
- q  out  WIDTH  shared register contents.
- ack0, ack1  out  1  one-cycle load acknowledge to requester 0 or 1.
- busy  out  1  high from grant until the hold period ends.
- owner  out  1  requester whose data is currently in q.

## Operation
- FSM states: IDLE, LOAD, HOLD. Reset puts the FSM in IDLE with q=0, sel=0, ack0=ack1=0, busy=0, owner=0, hold counter=0, and last-winner=1.
- IDLE: if no request is present, stay in IDLE. If exactly one request is present, grant that requester. If both are present, grant the one that is not last-winner.
  - On a grant: sel<=winner, busy<=1, and the FSM goes to LOAD.
- LOAD: q<=(sel ? d1 : d0); ackN<=1 for the winner; owner<=sel; last-winner<=sel; counter<=HOLD_CYCLES-1; the FSM goes to HOLD.
- HOLD: ackN<=0. If counter!=0, decrement it. If counter==0, go to IDLE and set busy<=0.
- Once granted, a request is committed. If req drops during LOAD, the load and the ack still occur.
- Data must be stable from request assertion until ack. d is sampled on the LOAD edge.
- A requester must drop req after seeing its ack. If req is still high when the FSM returns to IDLE, it counts as a new request.
- Requests arriving while busy=1 are ignored, not queued. They are evaluated when the FSM is next in IDLE.
- sel changes only on a grant edge. q changes only on a LOAD edge.

## Timing
- The request is sampled at edge n, which is the grant: sel and busy are valid after n.
- Edge n+1: q is updated and ack is high for exactly the cycle n+1..n+2.
- busy falls at edge n+1+HOLD_CYCLES. With HOLD_CYCLES=3 that is edge n+4.
- Earliest next grant edge: n+2+HOLD_CYCLES. Minimum period per grant is HOLD_CYCLES+2 cycles.
- Reset asserted mid-operation clears all outputs immediately (asynchronously). The first grant after deassertion is at the first rising edge with rst_n=1 and a request present.
- Both requests continuously high alternate grants 0,1,0,1,...; the first grant goes to 0.

## Configuration
- RR_PRIORITY_EN defined: ties are resolved round-robin as described above.
- RR_PRIORITY_EN undefined: fixed priority, where req0 always wins a tie. The last-winner register is removed, and owner still reports the current holder.

## Structure
- Shared package reg_share_pkg holds:
  - the state enum (IDLE, LOAD, HOLD);
  - the default WIDTH and HOLD_CYCLES constants;
  - the counter width constant (8 bits).
- One sub-module, reg_share_datapath: the WIDTH-bit 2:1 mux plus the async-reset load-enabled register. The FSM, counter and arbitration stay in the top.

## Test plan
- Reset: hold rst_n=0 and toggle clk with req0=1 and d0=4'hA. Expect q=0, busy=0, ack0=ack1=0 and sel=0 throughout.
- Single request: req0=1, d0=4'h5 at edge 0. Expect sel=0 and busy=1 after edge 0; q=4'h5 and ack0=1 after edge 1; ack0=0 after edge 2; busy=0 after edge 4 (HOLD_CYCLES=3).
- Tie, round-robin: req0=req1=1 with d0=4'h3 and d1=4'hC held high. Expect q to follow 3, C, 3, C with grant edges 5 cycles apart. Without RR_PRIORITY_EN, q stays 3 and only ack0 pulses.
- Request during busy: req1 asserted one cycle after req0's grant. Expect no ack1 until req0's hold ends; ack1 follows 2 cycles after the next IDLE edge.
- Withdrawn request: req0 pulsed for one cycle only, d0=4'h9. Expect the load and ack0 to still occur and q=4'h9.
- Mid-hold reset: pull rst_n low during HOLD with q=4'hF. Expect q=0 and busy=0 immediately with no clock edge. After release with no requests, expect the FSM to stay IDLE.

Source files
------------

// File: rtl/reg_share_pkg.sv
// reg_share_pkg: shared FSM state type and default sizing constants for
// reg_share_arbiter and its datapath.
package reg_share_pkg;

   // Controller states: wait for a request, load the winner, hold for display.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Default width of each requester's data and of the shared register.
   localparam int DEF_WIDTH       = 4;
   // Default number of cycles a loaded value is held (legal 1..255).
   localparam int DEF_HOLD_CYCLES = 3;
   // Hold counter width; covers the full 1..255 hold range.
   localparam int CNT_W           = 8;

endpackage

// File: rtl/reg_share_datapath.sv
// reg_share_datapath: WIDTH-bit 2:1 select mux feeding the shared holding
// register. The register loads only when the controller asserts i_load.
module reg_share_datapath
   import reg_share_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_sel,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d0,
   input  logic [WIDTH-1:0] i_d1,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] w_mux;
   logic [WIDTH-1:0] r_q;

   assign w_mux = i_sel ? i_d1 : i_d0;

   // Capture the selected requester's data on a load edge, hold it otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= w_mux;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: shares one WIDTH-bit holding register between two
// requesters. Grants one request, loads its data, acks it for one cycle and
// keeps the value on display for HOLD_CYCLES before the next grant.
// Optional feature: define RR_PRIORITY_EN for round-robin tie breaking;
// without it requester 0 always wins a tie and no last-winner state exists.
module reg_share_arbiter
   import reg_share_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   output logic             sel,
   output logic [WIDTH-1:0] q,
   output logic             ack0,
   output logic             ack1,
   output logic             busy,
   output logic             owner
);

   // LOAD already accounts for one held cycle, so the counter starts one lower.
   localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t           r_state;
   logic             r_sel;
   logic             r_ack0;
   logic             r_ack1;
   logic             r_busy;
   logic             r_owner;
   logic [CNT_W-1:0] r_cnt;
`ifdef RR_PRIORITY_EN
   logic             r_last;
`endif

   logic             w_any_req;
   logic             w_winner;
   logic             w_load;

   // Choose which requester would be granted if the FSM is idle this cycle.
   always_comb begin
      // NOTE: default assigned first so no path leaves w_winner unassigned (no latch).
      w_winner = 1'b0;
      if (req0 && req1) begin
`ifdef RR_PRIORITY_EN
         w_winner = ~r_last;
`else
         w_winner = 1'b0;
`endif
      end else if (req1) begin
         w_winner = 1'b1;
      end
   end

   assign w_any_req = req0 | req1;
   assign w_load    = (r_state == LOAD);

   // Grant / load / hold sequencing with all handshake outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sel   <= 1'b0;
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
         r_busy  <= 1'b0;
         r_owner <= 1'b0;
         r_cnt   <= '0;
`ifdef RR_PRIORITY_EN
         // Pretend requester 1 won last so the first tie goes to requester 0.
         r_last  <= 1'b1;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_sel   <= w_winner;
                  r_busy  <= 1'b1;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               // Grant is committed: load and ack even if the request dropped.
               r_ack0  <= ~r_sel;
               r_ack1  <= r_sel;
               r_owner <= r_sel;
`ifdef RR_PRIORITY_EN
               r_last  <= r_sel;
`endif
               r_cnt   <= HOLD_RELOAD;
               r_state <= HOLD;
            end
            HOLD: begin
               r_ack0 <= 1'b0;
               r_ack1 <= 1'b0;
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   reg_share_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sel  (r_sel),
      .i_load (w_load),
      .i_d0   (d0),
      .i_d1   (d1),
      .o_q    (q)
   );

   assign sel   = r_sel;
   assign ack0  = r_ack0;
   assign ack1  = r_ack1;
   assign busy  = r_busy;
   assign owner = r_owner;

endmodule
